cond_exec_unit: RTL and testbench
=================================

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 SHALL have parameter NUM_WEN, default 2; number of gated write-enable channels (bit 0 = register write, bit 1 = memory write).
REQ-002 SHALL have parameter TIMEOUT, default 15; maximum cycles spent waiting for pending flags.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1: instruction present at issue.
REQ-006 SHALL have port cond_i, input, 4: ARM condition field.
REQ-007 SHALL have port flag_w_i, input, 2: bit1 = NZ update, bit0 = CV update.
REQ-008 SHALL have port pcs_i, input, 1: instruction writes PC.
REQ-009 SHALL have port wen_i, input, NUM_WEN: ungated write enables.
REQ-010 SHALL have port flags_valid_i, input, 1: alu_flags_i carries the pending producer's flags.
REQ-011 SHALL have port alu_flags_i, input, 4: {N,Z,C,V}.
REQ-012 SHALL have port stall_o, output, 1: issue blocked this cycle.
REQ-013 SHALL have port cond_ex_o, output, 1: registered condition-passed result.
REQ-014 SHALL have port pc_src_o, output, 1: registered pcs_i AND pass.
REQ-015 SHALL have port wen_o, output, NUM_WEN: registered wen_i AND pass, per bit.
REQ-016 SHALL have port flags_o, output, 4: architectural NZCV register.
REQ-017 SHALL have port flag_err_o, output, 1: sticky flag-timeout error.

Function
REQ-018 SHALL accept an instruction when valid_i=1 and stall_o=0.
REQ-019 SHALL evaluate all 16 condition codes (EQ..AL, 1111 treated as AL) against the effective flags.
REQ-020 SHALL drive cond_ex_o, pc_src_o and wen_o one cycle after acceptance; in every cycle with no acceptance they SHALL be 0.
REQ-021 SHALL use a two-state FSM: IDLE and WAIT.
REQ-022 IDLE -> WAIT: on an accepted instruction with pass=1 and flag_w_i!=0. The per-pair mask is latched as flag_w_i.
REQ-023 A failed-condition instruction with flag_w_i!=0 SHALL NOT enter WAIT and SHALL NOT alter flags.
REQ-024 WAIT -> IDLE: on flags_valid_i=1. Update flags_o[3:2] if mask[1] and flags_o[1:0] if mask[0]; the new value is visible next cycle.
REQ-025 flags_valid_i in IDLE SHALL be ignored.
REQ-026 In WAIT, stall_o SHALL be 1 whenever valid_i=1 and (cond_i is not AL or flag_w_i!=0).
REQ-027 In WAIT, an AL instruction with flag_w_i=0 SHALL be accepted without stall.
REQ-028 In IDLE, stall_o SHALL be 0.
REQ-029 A wait counter SHALL clear on WAIT entry and increment each WAIT cycle without flags_valid_i.
REQ-030 When the counter reaches TIMEOUT: return to IDLE, leave flags unchanged, and set flag_err_o; flag_err_o stays set until reset.
REQ-031 The counter width SHALL be $clog2(TIMEOUT+1) and it SHALL never wrap.

Reset
REQ-032 On reset: FSM=IDLE, mask=0, counter=0, flags_o=4'b0000, flag_err_o=0, cond_ex_o=0, pc_src_o=0, wen_o=0.
REQ-033 Reset asserted in WAIT SHALL discard the pending update; a flags_valid_i in the reset cycle SHALL be ignored.

Configuration
REQ-034 Macro COND_FLAG_BYPASS_EN SHALL be the only compile option.
REQ-035 With COND_FLAG_BYPASS_EN defined: in WAIT with flags_valid_i=1, the instruction SHALL be evaluated on the merged flags (pending pairs from alu_flags_i, the rest from flags_o) and accepted that cycle (stall_o=0). If it also passes with flag_w_i!=0, the FSM SHALL re-enter WAIT with the new mask.
REQ-036 Without the macro: stall_o SHALL remain 1 in the flags_valid_i cycle, and the instruction is accepted the next cycle from IDLE.

Structure
REQ-037 Package cond_pkg SHALL hold the cond-code enum (EQ..NV), the N/Z/C/V bit-index constants and the FSM state enum.
REQ-038 Condition evaluation SHALL be one combinational sub-module, cond_eval (cond, flags -> pass).

Verification
REQ-039 After reset, issue cond=EQ, wen_i=2'b11 -> next cycle wen_o=00, cond_ex_o=0 (Z=0).
REQ-040 Issue AL, flag_w=11; flags_valid_i=1 with alu_flags=0100 two cycles later -> flags_o=0100; a queued EQ stalls until accepted, then wen_o=11.
REQ-041 Mask 10 pending, flags_o=0011, alu_flags=1100 -> flags_o=1111 (CV preserved).
REQ-042 In WAIT, issue AL, flag_w=00 -> no stall; wen_o follows wen_i.
REQ-043 WAIT with no flags_valid_i for 15 cycles -> IDLE, flag_err_o=1, flags unchanged; flag_err_o still 1 after 20 more cycles.
REQ-044 Bypass build: EQ issued in the same cycle as flags_valid_i, alu_flags=0100 -> stall_o=0, cond_ex_o=1 next cycle. Non-bypass build: one extra stall cycle.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the conditional execution unit: ARM condition codes,
// NZCV bit positions and the flag-wait FSM states.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions inside a {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition check: cond + {N,Z,C,V} -> pass.
// The NV encoding (1111) is treated as always-execute, like AL.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional execution unit: gates PC/register/memory writes on the ARM
// condition field and stalls issue while a flag update is still in flight.
// Compile option: COND_FLAG_BYPASS_EN lets an instruction be evaluated on
// the incoming producer flags in the same cycle they arrive, instead of
// waiting one more cycle for them to land in flags_o.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int NUM_WEN = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [3:0]         cond_i,
    input  logic [1:0]         flag_w_i,
    input  logic               pcs_i,
    input  logic [NUM_WEN-1:0] wen_i,
    input  logic               flags_valid_i,
    input  logic [3:0]         alu_flags_i,
    output logic               stall_o,
    output logic               cond_ex_o,
    output logic               pc_src_o,
    output logic [NUM_WEN-1:0] wen_o,
    output logic [3:0]         flags_o,
    output logic               flag_err_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_e        state_q;
    state_e        state_d;
    logic [1:0]    mask_q;
    logic [1:0]    mask_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    flags_d;
    logic          err_d;

    logic [3:0]    merged_flags;
    logic [3:0]    eval_flags;
    logic          pass;
    logic          is_al;
    logic          has_fw;
    logic          accept;

    // Pending pairs come from the producer, untouched pairs keep their value
    assign merged_flags = {mask_q[1] ? alu_flags_i[3:2] : flags_o[3:2],
                           mask_q[0] ? alu_flags_i[1:0] : flags_o[1:0]};

    assign is_al   = (cond_i == COND_AL) || (cond_i == COND_NV);
    assign has_fw  = (flag_w_i != 2'b00);
    assign cnt_inc = cnt_q + CW'(1);

    cond_eval u_cond_eval (
        .cond  (cond_i),
        .flags (eval_flags),
        .pass  (pass)
    );

    // Issue control: only flag-independent, flag-neutral work slips past a pending update
    always_comb begin
        stall_o    = 1'b0;
        eval_flags = flags_o;
        if (state_q == ST_WAIT) begin
`ifdef COND_FLAG_BYPASS_EN
            if (flags_valid_i) begin
                eval_flags = merged_flags;
            end else begin
                stall_o = valid_i && (!is_al || has_fw);
            end
`else
            stall_o = valid_i && (!is_al || has_fw);
`endif
        end
    end

    assign accept = valid_i && !stall_o;

    // Next-state logic for the flag-wait FSM, its mask, counter and the flag register
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        flags_d = flags_o;
        err_d   = flag_err_o;
        case (state_q)
            ST_IDLE: begin
                if (accept && pass && has_fw) begin
                    state_d = ST_WAIT;
                    mask_d  = flag_w_i;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (flags_valid_i) begin
                    flags_d = merged_flags;
                    state_d = ST_IDLE;
                    mask_d  = 2'b00;
                    // Only reachable with bypass: a flag-writer accepted on the arrival cycle
                    if (accept && pass && has_fw) begin
                        state_d = ST_WAIT;
                        mask_d  = flag_w_i;
                        cnt_d   = '0;
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_d   = cnt_inc;
                    state_d = ST_IDLE;
                    mask_d  = 2'b00;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = 2'b00;
            end
        endcase
    end

    // State register plus the registered, condition-gated issue outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= 2'b00;
            cnt_q      <= '0;
            flags_o    <= 4'b0000;
            flag_err_o <= 1'b0;
            cond_ex_o  <= 1'b0;
            pc_src_o   <= 1'b0;
            wen_o      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            flags_o    <= flags_d;
            flag_err_o <= err_d;
            cond_ex_o  <= accept && pass;
            pc_src_o   <= accept && pass && pcs_i;
            wen_o      <= (accept && pass) ? wen_i : '0;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit; expectations are hand-computed.
// Honours COND_FLAG_BYPASS_EN for the flag-arrival cycle expectations.
module tb_cond_exec_unit;
    import cond_pkg::*;

    logic       clk;
    logic       reset;
    logic       valid_i;
    logic [3:0] cond_i;
    logic [1:0] flag_w_i;
    logic       pcs_i;
    logic [1:0] wen_i;
    logic       flags_valid_i;
    logic [3:0] alu_flags_i;
    logic       stall_o;
    logic       cond_ex_o;
    logic       pc_src_o;
    logic [1:0] wen_o;
    logic [3:0] flags_o;
    logic       flag_err_o;

    int total;
    int bad;

    cond_exec_unit #(.NUM_WEN(2), .TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .cond_i        (cond_i),
        .flag_w_i      (flag_w_i),
        .pcs_i         (pcs_i),
        .wen_i         (wen_i),
        .flags_valid_i (flags_valid_i),
        .alu_flags_i   (alu_flags_i),
        .stall_o       (stall_o),
        .cond_ex_o     (cond_ex_o),
        .pc_src_o      (pc_src_o),
        .wen_o         (wen_o),
        .flags_o       (flags_o),
        .flag_err_o    (flag_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [1:0] fw,
                                 input logic pcs, input logic [1:0] wen,
                                 input logic fv, input logic [3:0] alu);
        valid_i       = v;
        cond_i        = c;
        flag_w_i      = fw;
        pcs_i         = pcs;
        wen_i         = wen;
        flags_valid_i = fv;
        alu_flags_i   = alu;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b0, 4'b0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pass_tbl;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyIdle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_flags", 8'(flags_o), 8'h0);
        checkOutput("rst_err", 8'(flag_err_o), 8'h0);
        checkOutput("rst_cond_ex", 8'(cond_ex_o), 8'h0);
        checkOutput("rst_wen", 8'(wen_o), 8'h0);
        checkOutput("rst_pc_src", 8'(pc_src_o), 8'h0);
        checkOutput("rst_stall", 8'(stall_o), 8'h0);

        // EQ with Z=0 fails: all gated outputs stay low
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b1, 2'b11, 1'b0, 4'b0000);
        #1 checkOutput("eq_stall", 8'(stall_o), 8'h0);
        tick();
        checkOutput("eq_fail_cond", 8'(cond_ex_o), 8'h0);
        checkOutput("eq_fail_wen", 8'(wen_o), 8'h0);
        checkOutput("eq_fail_pc", 8'(pc_src_o), 8'h0);

        // NE with Z=0 passes: outputs follow inputs
        applyStimulus(1'b1, COND_NE, 2'b00, 1'b1, 2'b11, 1'b0, 4'b0000);
        tick();
        checkOutput("ne_pass_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("ne_pass_wen", 8'(wen_o), 8'h3);
        checkOutput("ne_pass_pc", 8'(pc_src_o), 8'h1);
        applyIdle();
        tick();
        checkOutput("idle_cond", 8'(cond_ex_o), 8'h0);
        checkOutput("idle_wen", 8'(wen_o), 8'h0);

        // AL flag writer enters WAIT; a queued EQ stalls until the flags land
        applyStimulus(1'b1, COND_AL, 2'b11, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        checkOutput("al_fw_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("al_fw_wen", 8'(wen_o), 8'h0);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b11, 1'b0, 4'b0000);
        #1 checkOutput("wait_eq_stall", 8'(stall_o), 8'h1);
        tick();
        checkOutput("wait_eq_cond", 8'(cond_ex_o), 8'h0);
        checkOutput("wait_flags_hold", 8'(flags_o), 8'h0);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b11, 1'b1, 4'b0100);
`ifdef COND_FLAG_BYPASS_EN
        #1 checkOutput("fv_cycle_stall", 8'(stall_o), 8'h0);
        tick();
        checkOutput("fv_flags", 8'(flags_o), 8'h4);
        checkOutput("byp_eq_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("byp_eq_wen", 8'(wen_o), 8'h3);
`else
        #1 checkOutput("fv_cycle_stall", 8'(stall_o), 8'h1);
        tick();
        checkOutput("fv_flags", 8'(flags_o), 8'h4);
        checkOutput("fv_cycle_cond", 8'(cond_ex_o), 8'h0);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b11, 1'b0, 4'b0000);
        #1 checkOutput("after_fv_stall", 8'(stall_o), 8'h0);
        tick();
        checkOutput("late_eq_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("late_eq_wen", 8'(wen_o), 8'h3);
`endif
        applyIdle();
        tick();

        // Set flags to 0011, then update only the NZ pair with 1100
        applyStimulus(1'b1, COND_AL, 2'b11, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b0011);
        tick();
        checkOutput("flags_0011", 8'(flags_o), 8'h3);
        applyStimulus(1'b1, COND_AL, 2'b10, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b1100);
        tick();
        checkOutput("mask10_flags", 8'(flags_o), 8'hF);
        // flags_valid_i while idle is ignored
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b0000);
        tick();
        checkOutput("idle_fv_ignored", 8'(flags_o), 8'hF);

        // In WAIT, AL without flag write goes through unstalled
        applyStimulus(1'b1, COND_AL, 2'b01, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b1, COND_AL, 2'b00, 1'b1, 2'b10, 1'b0, 4'b0000);
        #1 checkOutput("wait_al_stall", 8'(stall_o), 8'h0);
        tick();
        checkOutput("wait_al_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("wait_al_wen", 8'(wen_o), 8'h2);
        checkOutput("wait_al_pc", 8'(pc_src_o), 8'h1);
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b0000);
        tick();
        checkOutput("mask01_flags", 8'(flags_o), 8'hC);

        // Failed flag-writer (CS with C=0) must not wait nor touch flags
        applyStimulus(1'b1, COND_CS, 2'b11, 1'b0, 2'b01, 1'b0, 4'b0000);
        tick();
        checkOutput("cs_fail_cond", 8'(cond_ex_o), 8'h0);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b01, 1'b1, 4'b0000);
        #1 checkOutput("no_wait_stall", 8'(stall_o), 8'h0);
        tick();
        checkOutput("no_wait_eq_cond", 8'(cond_ex_o), 8'h1);
        checkOutput("no_wait_flags", 8'(flags_o), 8'hC);

        // Every condition code against N=1 Z=1 C=0 V=0
        pass_tbl = 16'hEA99;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 2'b00, 1'b0, 2'b01, 1'b0, 4'b0000);
            tick();
            checkOutput($sformatf("cond_%0d", i), 8'(cond_ex_o), 8'(pass_tbl[i]));
        end
        applyIdle();
        tick();

        // Timeout: 15 WAIT cycles without flags -> IDLE with sticky error
        applyStimulus(1'b1, COND_AL, 2'b11, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b01, 1'b0, 4'b0000);
        #1 checkOutput("to_wait_stall", 8'(stall_o), 8'h1);
        applyIdle();
        for (int i = 0; i < 14; i++) tick();
        checkOutput("to_err_early", 8'(flag_err_o), 8'h0);
        tick();
        checkOutput("to_err_set", 8'(flag_err_o), 8'h1);
        checkOutput("to_flags_kept", 8'(flags_o), 8'hC);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b01, 1'b0, 4'b0000);
        #1 checkOutput("to_idle_stall", 8'(stall_o), 8'h0);
        applyIdle();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("to_err_sticky", 8'(flag_err_o), 8'h1);

        // Reset in WAIT drops the pending update, even with flags arriving
        applyStimulus(1'b1, COND_AL, 2'b11, 1'b0, 2'b00, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b1010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_wait_flags", 8'(flags_o), 8'h0);
        checkOutput("rst_wait_err", 8'(flag_err_o), 8'h0);
        applyStimulus(1'b0, COND_AL, 2'b00, 1'b0, 2'b00, 1'b1, 4'b1111);
        tick();
        checkOutput("rst_idle_fv", 8'(flags_o), 8'h0);
        applyStimulus(1'b1, COND_EQ, 2'b00, 1'b0, 2'b01, 1'b0, 4'b0000);
        #1 checkOutput("rst_idle_stall", 8'(stall_o), 8'h0);
        applyIdle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
